// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forward selects, result-source
// encoding and the divide-tracker state.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } forward_sel_t;

  typedef enum logic {
    IDLE     = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_div_tracker.sv
// Tracks a multi-cycle divide sitting in E: holds the pipe for DIV_CYCLES-1 cycles
// and pulses done on the last one. Memory stalls freeze the whole tracker.
module hazard_div_tracker
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic start_i,
  input  logic memstall_i,
  output logic divstall_o,
  output logic busy_o,
  output logic done_o
);

  localparam int CW = $clog2(DIV_CYCLES);

  div_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Start cycle counts as the first of DIV_CYCLES, and the cnt==0 cycle as the last.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    divstall_o = 1'b0;
    done_o     = 1'b0;
    case (state_q)
      IDLE: begin
        divstall_o = start_i;
        if (start_i && !memstall_i) begin
          state_d = DIV_BUSY;
          cnt_d   = CW'(DIV_CYCLES - 2);
        end
      end
      DIV_BUSY: begin
        if (cnt_q != '0) begin
          divstall_o = 1'b1;
          if (!memstall_i) cnt_d = cnt_q - CW'(1);
        end else if (!memstall_i) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == DIV_BUSY);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard unit: operand forwarding, load-use/divide/memory stalls
// and flushes. Optional perf counters are built when HAZARD_PERF_COUNTERS_EN is defined.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REGISTER_ADDRESS_WIDTH = 5,
  parameter int DIV_CYCLES             = 32,
  parameter int PERF_WIDTH             = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i,
  input  logic [1:0]                        ResultSrcE_i,
  input  logic                              DivStartE_i,
  input  logic                              PCSrcE_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i,
  input  logic                              RegWriteM_i,
  input  logic                              MemReqM_i,
  input  logic                              MemReadyM_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
  input  logic                              RegWriteW_i,
  output logic [1:0]                        ForwardAE_o,
  output logic [1:0]                        ForwardBE_o,
  output logic                              StallF_o,
  output logic                              StallD_o,
  output logic                              StallE_o,
  output logic                              StallM_o,
  output logic                              FlushD_o,
  output logic                              FlushE_o,
  output logic                              FlushM_o,
  output logic                              FlushW_o,
  output logic                              DivBusy_o,
  output logic                              DivDoneE_o
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  output logic [PERF_WIDTH-1:0]             StallCycles_o,
  output logic [PERF_WIDTH-1:0]             FlushCount_o
`endif
);

  localparam int AW = REGISTER_ADDRESS_WIDTH;

  if (DIV_CYCLES < 2 || PERF_WIDTH < 1) begin : g_cfg_err
    $error("pipeline_hazard_ctrl: DIV_CYCLES must be >= 2 and PERF_WIDTH >= 1");
  end

  logic memstall, divstall, lwstall, div_busy, div_done;
  forward_sel_t fwd_a, fwd_b;

  function automatic forward_sel_t fwd_sel(input logic [AW-1:0] rs,
                                           input logic [AW-1:0] rd_m, input logic we_m,
                                           input logic [AW-1:0] rd_w, input logic we_w);
    if (we_m && rd_m != '0 && rd_m == rs)      return FWD_M;
    else if (we_w && rd_w != '0 && rd_w == rs) return FWD_W;
    else                                       return FWD_NONE;
  endfunction

  assign fwd_a    = fwd_sel(Rs1E_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i);
  assign fwd_b    = fwd_sel(Rs2E_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i);
  assign memstall = MemReqM_i & ~MemReadyM_i;

  hazard_div_tracker #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .start_i    (DivStartE_i),
    .memstall_i (memstall),
    .divstall_o (divstall),
    .busy_o     (div_busy),
    .done_o     (div_done)
  );

  // Load-use is only a separate hazard when nothing bigger is already holding E.
  assign lwstall = (ResultSrcE_i == RESULT_SRC_LOAD) && (RdE_i != '0) &&
                   ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i)) && !memstall && !divstall;

  // Every output is forced low while reset is held, combinational paths included.
  always_comb begin
    ForwardAE_o = rst_n_i ? fwd_a : FWD_NONE;
    ForwardBE_o = rst_n_i ? fwd_b : FWD_NONE;
    StallF_o    = rst_n_i & (memstall | divstall | lwstall);
    StallD_o    = StallF_o;
    StallE_o    = rst_n_i & (memstall | divstall);
    StallM_o    = rst_n_i & memstall;
    FlushW_o    = StallM_o;
    FlushM_o    = rst_n_i & divstall & ~memstall;
    FlushE_o    = rst_n_i & (lwstall | PCSrcE_i) & ~memstall & ~divstall;
    FlushD_o    = rst_n_i & PCSrcE_i & ~memstall;
    DivBusy_o   = rst_n_i & div_busy;
    DivDoneE_o  = rst_n_i & div_done;
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [PERF_WIDTH-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallF_o && !(&stall_cnt_q))              stall_cnt_d = stall_cnt_q + 1'b1;
    if ((FlushD_o || FlushE_o) && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCycles_o = stall_cnt_q;
  assign FlushCount_o  = flush_cnt_q;
`endif

endmodule
